seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 100 ++++++++++
 tb/tb_seq_detect_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern, length and overlap mode.
// Mealy match pulse plus registered copy, saturating match counter and cfg error pulse.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b0000_1010),
    parameter int                 DEFAULT_LEN = 4,
    parameter bit                 DEFAULT_OVL = 1'b1,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_in,
    input  logic               data_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               data_out,
    output logic               data_out_q,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [CNT_W-1:0]   r_count;
    logic               r_out_q;
    logic               r_cfg_err;

    logic               w_cfg_ok;
    logic [MAX_LEN-1:0] w_cand;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;

    assign w_cfg_ok = cfg_we && (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
    assign w_cand   = {r_hist[MAX_LEN-2:0], data_in};

    // Only the low L pattern bits take part in the comparison.
    // NOTE: every always_comb output gets a default before any conditional logic so no latch is inferred.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = data_valid && !cfg_we && !rst
                     && (r_fill >= (r_len - LEN_W'(1)))
                     && (((w_cand ^ r_pat) & w_mask) == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= DEFAULT_PAT;
            r_len     <= LEN_W'(DEFAULT_LEN);
            r_ovl     <= DEFAULT_OVL;
            r_count   <= '0;
            r_out_q   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_out_q   <= w_match;
            r_cfg_err <= cfg_we && !w_cfg_ok;

            if (w_cfg_ok) begin
                r_pat  <= cfg_pat;
                r_len  <= cfg_len;
                r_ovl  <= cfg_ovl;
                r_hist <= '0;
                r_fill <= '0;
            end else if (data_valid) begin
                r_hist <= w_cand;
                // Non-overlapping mode restarts the fill so matched bits are never reused.
                if (w_match && !r_ovl) begin
                    r_fill <= '0;
                end else if (r_fill < r_len) begin
                    r_fill <= r_fill + LEN_W'(1);
                end
            end

            if (cnt_clr) begin
                r_count <= '0;
            end else if (w_match && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign data_out    = w_match;
    assign data_out_q  = r_out_q;
    assign match_count = r_count;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: expected match pulses go through a scoreboard queue.
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               data_in;
    logic               data_valid;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic               cnt_clr;
    logic               data_out,   data_out2;
    logic               data_out_q, data_out_q2;
    logic [7:0]         match_count;
    logic [1:0]         match_count2;
    logic               cfg_err,    cfg_err2;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic prev_exp = 1'b0;
    bit   q_armed  = 1'b0;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .cnt_clr(cnt_clr), .data_out(data_out), .data_out_q(data_out_q),
        .match_count(match_count), .cfg_err(cfg_err)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .cnt_clr(cnt_clr), .data_out(data_out2), .data_out_q(data_out_q2),
        .match_count(match_count2), .cfg_err(cfg_err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    // Inputs are already driven; sample mid-cycle, then advance past the next rising edge.
    task automatic step(input logic exp_out);
        logic want;
        exp_q.push_back(exp_out);
        @(negedge clk);
        want = exp_q.pop_front();
        check("data_out", {31'b0, data_out}, {31'b0, want});
        if (q_armed) check("data_out_q", {31'b0, data_out_q}, {31'b0, prev_exp});
        prev_exp = want;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cfg_we  = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic bit_in(input logic din, input logic exp_out);
        data_valid = 1'b1;
        data_in    = din;
        step(exp_out);
    endtask

    task automatic gap(input logic din);
        data_valid = 1'b0;
        data_in    = din;
        step(1'b0);
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                            input logic ovl);
        cfg_we     = 1'b1;
        cfg_pat    = pat;
        cfg_len    = len;
        cfg_ovl    = ovl;
        data_valid = 1'b1;
        data_in    = 1'b1;
        step(1'b0);
    endtask

    task automatic clear_cnt();
        cnt_clr    = 1'b1;
        data_valid = 1'b0;
        step(1'b0);
    endtask

    initial begin
        // Reset must dominate a valid configuration write, a clear and valid data.
        rst = 1'b1; cfg_we = 1'b1; cfg_pat = 8'b110; cfg_len = 3; cfg_ovl = 1'b0;
        cnt_clr = 1'b1; data_valid = 1'b1; data_in = 1'b1;
        step(1'b0);
        q_armed = 1'b1;
        rst = 1'b1; cfg_we = 1'b1; data_valid = 1'b1;
        step(1'b0);
        check("reset_count", {24'b0, match_count}, 32'd0);
        check("reset_cfg_err", {31'b0, cfg_err}, 32'd0);

        // Defaults, overlapping 1010.
        for (int i = 0; i < 8; i++) bit_in(~i[0], (i == 3) || (i == 5) || (i == 7));
        check("ovl_count", {24'b0, match_count}, 32'd3);
        clear_cnt();
        check("clr_count", {24'b0, match_count}, 32'd0);

        // Non-overlapping 1010.
        load_cfg(8'b1010, 4, 1'b0);
        for (int i = 0; i < 8; i++) bit_in(~i[0], (i == 3) || (i == 7));
        check("novl_count", {24'b0, match_count}, 32'd2);

        // data_valid gaps hold history.
        load_cfg(8'b1010, 4, 1'b1);
        clear_cnt();
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        gap(1'b1); gap(1'b0); gap(1'b1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b1);
        check("gap_count", {24'b0, match_count}, 32'd1);

        // Three-bit pattern, then a rejected length that must keep 110 active.
        load_cfg(8'b110, 3, 1'b1);
        bit_in(1'b1, 1'b0); bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b0); bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b1);
        load_cfg(8'hFF, 0, 1'b0);
        check("cfg_err_pulse", {31'b0, cfg_err}, 32'd1);
        bit_in(1'b1, 1'b0);
        check("cfg_err_drop", {31'b0, cfg_err}, 32'd0);
        bit_in(1'b0, 1'b1);
        load_cfg(8'hFF, 9, 1'b0);
        check("cfg_err_over", {31'b0, cfg_err}, 32'd1);

        // Saturation on the 2-bit counter instance, then clear beats a match.
        load_cfg(8'b10, 2, 1'b1);
        clear_cnt();
        for (int i = 0; i < 5; i++) begin
            bit_in(1'b1, 1'b0);
            bit_in(1'b0, 1'b1);
        end
        check("sat_count2", {30'b0, match_count2}, 32'd3);
        check("nosat_count", {24'b0, match_count}, 32'd5);
        bit_in(1'b1, 1'b0);
        cnt_clr = 1'b1;
        bit_in(1'b0, 1'b1);
        check("clr_vs_match", {24'b0, match_count}, 32'd0);
        check("clr_vs_match2", {30'b0, match_count2}, 32'd0);

        // Reset mid-sequence discards partial history.
        rst = 1'b1;
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        rst = 1'b1;
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b0);
        check("post_rst_q", {31'b0, data_out_q}, 32'd0);
        check("post_rst_count", {24'b0, match_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
